bcd_seg_scan: RTL
=================

// Module: bcd_seg_scan
// PURPOSE
//  Time-multiplexed 7-segment display driver; downstream consumer of bin2bcd output.
//  Latches a packed BCD word on a load strobe and scans its digits one at a time onto a
//  common segment bus with one-hot anode enables. Sits between bin2bcd (fed by the multiplier
//  product) and the board display pins.
// PARAMETERS
//  BCD_W     10    width of bcd_in (bin2bcd output for W=8); zero-extended to 4*DIGITS
//  DIGITS    3     number of display digits scanned, 1..8
//  PRESCALE  50000 clk cycles each digit stays lit, >=2
//  LZB       1     1 = blank leading zeros, 0 = show all digits
// PORTS
//  clk         in   1         system clock, all state on rising edge
//  rst         in   1         synchronous, active-high reset
//  load        in   1         capture bcd_in into shadow register this edge
//  bcd_in      in   BCD_W     packed BCD, digit k = bits [4k+3:4k], k=0 least significant
//  blank       in   1         1 = all anodes off
//  an          out  DIGITS    anode enables, active-low, one-hot-low when lit
//  seg         out  7         segments {g,f,e,d,c,b,a}, active-low
//  frame_done  out  1         1-cycle pulse when the scan wraps from digit DIGITS-1 to 0
// BEHAVIOUR
//  Reset (rst=1 at edge): shadow=0, pre_cnt=0, idx=0, an=all 1s, seg=7'h7F, frame_done=0.
//  Reset takes priority over load and tick; a mid-scan reset restarts at digit 0.
//  Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps; tick = (pre_cnt==PRESCALE-1).
//  On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1. frame_done <= tick && idx==DIGITS-1.
//  load=1: shadow <= zero-extended bcd_in on that edge; load has no effect on pre_cnt/idx.
//  Outputs are registered from current idx/shadow/blank (1-cycle latency):
//   an  <= blank ? all 1s : ~(1<<idx); seg <= blanked ? 7'h7F : decode(shadow digit idx).
//  First edge after reset release: an=~1 (digit 0 lit). Each digit is lit PRESCALE cycles.
//  Load and tick on the same edge: both apply; next edge shows the new digit from new data.
//  Leading-zero blank (LZB=1): digit k>0 blanked (seg=7'h7F, an still driven) when digits
//   k..DIGITS-1 of shadow are all 0. Digit 0 is never blanked, so value 0 shows "0".
//  Digit values 10..15 (invalid BCD) show '-' (seg=7'h3F, only g lit); they count as
//   nonzero for blanking.
//  Decode (active-low, gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
//  blank affects only an, one cycle later; prescaler and idx keep running.
// STRUCTURE
//  Package seg_pkg: SEG_OFF=7'h7F, SEG_DASH=7'h3F, the 16-entry decode constant table, and
//   function clog2 for the idx width (max(1,clog2(DIGITS))).
//  One sub-module: seg7_decode (4-bit digit -> 7-bit active-low pattern, combinational).
//  Top holds shadow register, prescaler, idx counter, blanking logic, output registers.
// TESTING (bench: DIGITS=3, PRESCALE=4, BCD_W=10)
//  Reset 3 cycles, release -> first edge an=3'b110, seg=7'h40; an changes every 4 cycles 110->101->011->110.
//  load bcd_in=10'h123 -> digit0 seg=7'h30, digit1 7'h24, digit2 7'h79; frame_done pulses once every 12 cycles.
//  load 10'h007, LZB=1 -> digit0 7'h78, digits 1 and 2 seg=7'h7F with an still driven; LZB=0 -> 7'h40.
//  load 10'h0A5 -> digit1 shows 7'h3F, digit2 blanked, digit0 7'h12; load 0 -> only digit0 shows 7'h40.
//  blank=1 mid-scan -> an=3'b111 next edge, idx continues; blank=0 -> the rotation resumes with no phase loss.
//  rst pulse mid-frame with load=1 -> shadow=0, next edge after release an=3'b110, seg=7'h40.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, segment decode table and width helper for the display scanner
package seg_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Packed decode table: entry k lives at bits [7k+6:7k]; 10..15 show a dash
  localparam logic [16*7-1:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Ceiling log2, used to size counters; returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 4-bit digit to active-low 7-segment pattern
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup; invalid BCD codes map to the dash entries
  always_comb begin
    seg = SEG_TABLE[7*int'(digit) +: 7];
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - time-multiplexed 7-segment scanner for a latched packed BCD word
module bcd_seg_scan
  import seg_pkg::*;
#(
  parameter int BCD_W    = 10,
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 50000,
  parameter int LZB      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BCD_W-1:0]  bcd_in,
  input  logic              blank,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              frame_done
);

  localparam int SH_W  = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? clog2(PRESCALE) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [SH_W-1:0]   shadow;
  logic [SH_W-1:0]   bcd_ext;
  logic [PRE_W-1:0]  pre_cnt;
  logic [IDX_W-1:0]  idx;
  logic              tick;
  logic [DIGITS-1:0] zero_above;
  logic [3:0]        cur_digit;
  logic              cur_zero_above;
  logic              blanked;
  logic [DIGITS-1:0] an_lit;
  logic [6:0]        dec_seg;

  // Zero-extend (or trim) the incoming word to the shadow width
  if (BCD_W >= SH_W) begin : g_trim
    assign bcd_ext = bcd_in[SH_W-1:0];
  end else begin : g_ext
    assign bcd_ext = {{(SH_W-BCD_W){1'b0}}, bcd_in};
  end

  assign tick = (pre_cnt == PRE_LAST);

  // Shadow register captures a new display value on load
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= bcd_ext;
    end
  end

  // Prescaler sets how long each digit stays lit
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Digit index advances on each tick and wraps after the last digit
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // zero_above[k]: digits k..DIGITS-1 of the shadow are all zero
  always_comb begin
    logic acc;
    acc = 1'b1;
    zero_above = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc = acc && (shadow[4*k +: 4] == 4'h0);
      zero_above[k] = acc;
    end
  end

  // Select the current digit, its leading-zero flag and its anode pattern
  always_comb begin
    cur_digit      = 4'h0;
    cur_zero_above = 1'b0;
    an_lit         = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit      = shadow[4*k +: 4];
        cur_zero_above = zero_above[k];
        an_lit[k]      = 1'b0;
      end
    end
  end

  // Digit 0 is never blanked so a zero value still shows "0"
  assign blanked = (LZB != 0) && (idx != '0) && cur_zero_above;

  seg7_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Registered outputs: anodes, segments and the frame wrap pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      an         <= blank ? '1 : an_lit;
      seg        <= blanked ? SEG_OFF : dec_seg;
      frame_done <= tick && (idx == IDX_LAST);
    end
  end

endmodule
